// File: rtl/bus_arbiter_mux_pkg.sv
// Shared constants for the bus arbiter/mux: source indices, arbitration modes,
// statistics counter width and a saturating increment helper.
package bus_arbiter_mux_pkg;

    // Bus source indices
    localparam int SRC_R0     = 0;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHIGH  = 18;
    localparam int SRC_ZLOW   = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_CSIGN  = 23;

    // Arbitration modes
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    localparam int CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bus_arbiter_mux_if.sv
// Bundle of source-side request/data signals and registered bus outputs.
// Handshake: a source holds req high for as long as it wants the bus; it owns
// the bus in every cycle its gnt bit is high, and bus_valid qualifies bus_out.
interface bus_arbiter_mux_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 24,
    parameter int SEL_W   = $clog2(NUM_SRC)
);
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       req;
    logic                     clr_stats;
    logic [NUM_SRC-1:0]       gnt;
    logic [SEL_W-1:0]         gnt_idx;
    logic [WIDTH-1:0]         bus_out;
    logic                     bus_valid;
    logic                     conflict;
    logic [15:0]              conflict_cnt;

    modport master (
        output src_data, req, clr_stats,
        input  gnt, gnt_idx, bus_out, bus_valid, conflict, conflict_cnt
    );

    modport slave (
        input  src_data, req, clr_stats,
        output gnt, gnt_idx, bus_out, bus_valid, conflict, conflict_cnt
    );
endinterface

// File: rtl/bus_arbiter_mux_rr_arbiter.sv
// Combinational arbiter: fixed priority (lowest index) or round-robin built as
// masked priority starting after ptr, with an unmasked fallback for wrap-around.
import bus_arbiter_mux_pkg::*;

module rr_arbiter #(
    parameter int N     = 24,
    parameter int MODE  = MODE_FIXED,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] idx
);
    logic [N-1:0] elig;
    logic [N-1:0] upper;
    logic [N-1:0] pick;
    logic         found;

    // Pick the first eligible requester, searching above ptr first in RR mode
    always_comb begin
        elig  = req & mask;
        upper = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = (i > int'(ptr));
        end
        pick = elig;
        if ((MODE == MODE_RR) && ((elig & upper) != '0)) begin
            pick = elig & upper;
        end
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pick[i] && !found) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = SEL_W'(i);
            end
        end
    end
endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered shared-bus arbiter and data mux with ownership hold, tenure limit,
// idle policy and saturating conflict statistics.
import bus_arbiter_mux_pkg::*;

module bus_arbiter_mux #(
    parameter int WIDTH     = 32,
    parameter int NUM_SRC   = 24,
    parameter int SEL_W     = $clog2(NUM_SRC),
    parameter int MODE      = MODE_FIXED,
    parameter int HOLD_IDLE = 1,
    parameter int MAX_HOLD  = 0
) (
    input  logic               clk,
    input  logic               clr,
    bus_arbiter_mux_if.slave   bus
);
    // Tenure counts keep-cycles after the grant cycle, so the owner is forced
    // off once it has held the bus for MAX_HOLD cycles in total.
    localparam int TEN_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    logic [NUM_SRC-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]   bus_q, bus_d;
    logic               valid_q, valid_d;
    logic               conflict_q, conflict_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   tenure_q, tenure_d;

    logic               owner_req;
    logic               others_req;
    logic               limit_hit;
    logic               keep;
    logic [NUM_SRC-1:0] arb_gnt;
    logic [SEL_W-1:0]   arb_idx;
    logic [SEL_W-1:0]   sel;

    // The current owner is excluded through the mask; it only matters when it
    // is being forced off, since a dropped owner is not requesting anyway.
    rr_arbiter #(.N(NUM_SRC), .MODE(MODE), .SEL_W(SEL_W)) u_arb (
        .req  (bus.req),
        .mask (~gnt_q),
        .ptr  (ptr_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    // Ownership decision: keep the grant unless the owner dropped or hit its tenure limit
    always_comb begin
        owner_req  = (gnt_q & bus.req) != '0;
        others_req = (bus.req & ~gnt_q) != '0;
        limit_hit  = (MAX_HOLD != 0) && (tenure_q >= CNT_W'(TEN_LIM));
        keep       = owner_req && !(limit_hit && others_req);
        sel        = keep ? gnt_idx_q : arb_idx;
    end

    // Next grant, bus value, pointer, tenure and statistics
    always_comb begin
        gnt_d     = '0;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        valid_d   = 1'b0;
        tenure_d  = '0;
        bus_d     = (HOLD_IDLE != 0) ? bus_q : '0;
        if (keep) begin
            gnt_d    = gnt_q;
            valid_d  = 1'b1;
            tenure_d = sat_inc(tenure_q);
            bus_d    = bus.src_data[int'(sel)*WIDTH +: WIDTH];
        end else if (arb_gnt != '0) begin
            gnt_d     = arb_gnt;
            gnt_idx_d = arb_idx;
            ptr_d     = arb_idx;
            valid_d   = 1'b1;
            bus_d     = bus.src_data[int'(sel)*WIDTH +: WIDTH];
        end
        conflict_d = (bus.req & (bus.req - NUM_SRC'(1))) != '0;
        if (bus.clr_stats) begin
            cnt_d = '0;
        end else if (conflict_d) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            ptr_q      <= '0;
            bus_q      <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
            tenure_q   <= '0;
        end else begin
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            ptr_q      <= ptr_d;
            bus_q      <= bus_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
            tenure_q   <= tenure_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.gnt_idx      = gnt_idx_q;
    assign bus.bus_out      = bus_q;
    assign bus.bus_valid    = valid_q;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench: three arbiter configurations share one stimulus stream.
// d0: fixed priority, hold idle; d1: round-robin; d2: fixed, MAX_HOLD=3, zero idle.
import bus_arbiter_mux_pkg::*;

module tb_bus_arbiter_mux;
    localparam int W = 32;
    localparam int N = 24;

    logic           clk = 1'b0;
    logic           clr;
    logic [N-1:0]   req_v;
    logic [N*W-1:0] src_v;
    logic           clr_stats_v;
    int             errors = 0;
    int             checks = 0;

    // Clock
    always #5 clk = ~clk;

    bus_arbiter_mux_if #(.WIDTH(W), .NUM_SRC(N)) if0 ();
    bus_arbiter_mux_if #(.WIDTH(W), .NUM_SRC(N)) if1 ();
    bus_arbiter_mux_if #(.WIDTH(W), .NUM_SRC(N)) if2 ();

    assign if0.req = req_v;  assign if0.src_data = src_v;  assign if0.clr_stats = clr_stats_v;
    assign if1.req = req_v;  assign if1.src_data = src_v;  assign if1.clr_stats = clr_stats_v;
    assign if2.req = req_v;  assign if2.src_data = src_v;  assign if2.clr_stats = clr_stats_v;

    bus_arbiter_mux #(.WIDTH(W), .NUM_SRC(N), .MODE(MODE_FIXED), .HOLD_IDLE(1), .MAX_HOLD(0))
        d0 (.clk(clk), .clr(clr), .bus(if0));
    bus_arbiter_mux #(.WIDTH(W), .NUM_SRC(N), .MODE(MODE_RR), .HOLD_IDLE(1), .MAX_HOLD(0))
        d1 (.clk(clk), .clr(clr), .bus(if1));
    bus_arbiter_mux #(.WIDTH(W), .NUM_SRC(N), .MODE(MODE_FIXED), .HOLD_IDLE(0), .MAX_HOLD(3))
        d2 (.clk(clk), .clr(clr), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] bit_of(input int i);
        return N'(1) << i;
    endfunction

    initial begin
        clr         = 1'b1;
        req_v       = '0;
        clr_stats_v = 1'b0;
        for (int i = 0; i < N; i++) src_v[i*W +: W] = 32'h5A00_0000 | 32'(i);

        // Reset state
        #2;
        chk("rst_gnt",   32'(if0.gnt), 32'h0);
        chk("rst_idx",   32'(if0.gnt_idx), 32'h0);
        chk("rst_bus",   if0.bus_out, 32'h0);
        chk("rst_valid", 32'(if0.bus_valid), 32'h0);
        chk("rst_conf",  32'(if0.conflict), 32'h0);
        chk("rst_cnt",   32'(if0.conflict_cnt), 32'h0);
        req_v = bit_of(5);
        tick();
        chk("rst_held_valid", 32'(if0.bus_valid), 32'h0);
        clr = 1'b0;

        // Test 1: owner 5, then clear mid-tenure
        tick();
        chk("t1_own5_idx", 32'(if0.gnt_idx), 32'd5);
        chk("t1_own5_gnt", 32'(if0.gnt), 32'(bit_of(5)));
        chk("t1_own5_bus", if0.bus_out, 32'h5A00_0005);
        tick();
        clr = 1'b1;
        #1;
        chk("t1_clr_gnt",   32'(if0.gnt), 32'h0);
        chk("t1_clr_idx",   32'(if0.gnt_idx), 32'h0);
        chk("t1_clr_bus",   if0.bus_out, 32'h0);
        chk("t1_clr_valid", 32'(if0.bus_valid), 32'h0);
        clr   = 1'b0;
        req_v = bit_of(3);
        tick();
        chk("t1_rel_gnt", 32'(if0.gnt), 32'(bit_of(3)));
        chk("t1_rel_idx", 32'(if0.gnt_idx), 32'd3);

        // Test 2: fixed priority with conflict
        src_v[2*W +: W] = 32'hAAAA_0002;
        req_v = bit_of(2) | bit_of(7);
        tick();
        chk("t2_idx",  32'(if0.gnt_idx), 32'd2);
        chk("t2_bus",  if0.bus_out, 32'hAAAA_0002);
        chk("t2_conf", 32'(if0.conflict), 32'd1);
        chk("t2_cnt",  32'(if0.conflict_cnt), 32'd1);

        // Test 5: idle policy
        src_v[6*W +: W] = 32'h1234_5678;
        req_v = bit_of(6);
        tick();
        chk("t5_own_bus0", if0.bus_out, 32'h1234_5678);
        chk("t5_own_bus2", if2.bus_out, 32'h1234_5678);
        chk("t5_conf_off", 32'(if0.conflict), 32'd0);
        req_v = '0;
        tick();
        chk("t5_idle_bus_hold", if0.bus_out, 32'h1234_5678);
        chk("t5_idle_valid",    32'(if0.bus_valid), 32'd0);
        chk("t5_idle_gnt",      32'(if0.gnt), 32'h0);
        chk("t5_idle_idx",      32'(if0.gnt_idx), 32'd6);
        chk("t5_idle_bus_zero", if2.bus_out, 32'h0);
        chk("t5_idle_valid2",   32'(if2.bus_valid), 32'd0);

        // Test 4: tenure limit on d2, unlimited on d0
        req_v = bit_of(4) | bit_of(9);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t4_hold4_idx", 32'(if2.gnt_idx), 32'd4);
        end
        tick();
        chk("t4_pass9_idx", 32'(if2.gnt_idx), 32'd9);
        chk("t4_pass9_gnt", 32'(if2.gnt), 32'(bit_of(9)));
        chk("t4_pass9_bus", if2.bus_out, 32'h5A00_0009);
        chk("t4_nolim_idx", 32'(if0.gnt_idx), 32'd4);
        tick();
        chk("t4_keep9_idx", 32'(if2.gnt_idx), 32'd9);
        req_v = '0;
        tick();
        req_v = bit_of(4);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t4_alone4_gnt", 32'(if2.gnt), 32'(bit_of(4)));
        end

        // Test 3: round-robin wrap without bubbles
        req_v = '0;
        tick();
        req_v = bit_of(SRC_CSIGN);
        tick();
        chk("t3_seed23", 32'(if1.gnt_idx), 32'd23);
        req_v = bit_of(SRC_R0) | bit_of(1);
        tick();
        chk("t3_rr0", 32'(if1.gnt_idx), 32'd0);
        req_v = bit_of(1) | bit_of(SRC_CSIGN);
        tick();
        chk("t3_rr1", 32'(if1.gnt_idx), 32'd1);
        chk("t3_rr1_valid", 32'(if1.bus_valid), 32'd1);
        req_v = bit_of(SRC_R0) | bit_of(SRC_CSIGN);
        tick();
        chk("t3_rr23", 32'(if1.gnt_idx), 32'd23);
        chk("t3_rr23_bus", if1.bus_out, 32'h5A00_0017);
        chk("t3_fixed0", 32'(if0.gnt_idx), 32'd0);
        req_v = bit_of(SRC_R0) | bit_of(1);
        tick();
        chk("t3_wrap0", 32'(if1.gnt_idx), 32'd0);
        chk("t3_wrap0_valid", 32'(if1.bus_valid), 32'd1);
        tick();
        chk("t3_keep0", 32'(if1.gnt_idx), 32'd0);

        // Test 6: counter clear priority and saturation
        clr_stats_v = 1'b1;
        tick();
        chk("t6_clr_wins", 32'(if0.conflict_cnt), 32'h0);
        clr_stats_v = 1'b0;
        repeat (65534) tick();
        chk("t6_cnt_fffe", 32'(if0.conflict_cnt), 32'hFFFE);
        tick();
        chk("t6_cnt_ffff", 32'(if0.conflict_cnt), 32'hFFFF);
        tick();
        chk("t6_cnt_sat", 32'(if0.conflict_cnt), 32'hFFFF);
        clr_stats_v = 1'b1;
        tick();
        chk("t6_clr_sat", 32'(if0.conflict_cnt), 32'h0);
        clr_stats_v = 1'b0;
        tick();
        chk("t6_restart", 32'(if0.conflict_cnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
